l1inv_pktq: RTL and testbench
=============================

// Module: l1inv_pktq
// PURPOSE
//  Downstream of the L1 directory. Captures each directory lookup result a fixed
//  number of cycles after its strobe, drops results with no L1 hit, and queues the
//  rest in a small FIFO. Drains the FIFO as 112-bit invalidation packets toward
//  the CPX return-path formatter. Ifill lookups may produce two packets (way-0 and
//  way-1 vectors). Provides back-pressure (q_full) to the request issuer.
// PARAMETERS
//  DIR_LAT  1  cycles from strobe to valid directory outputs; legal range 1..4
//  DEPTH    4  FIFO entries; power of two, 2..16
// PORTS
//  clk           in   1    clock, all state on rising edge
//  reset         in   1    asynchronous, active-low reset
//  strobe        in   1    directory lookup issued this cycle
//  needinv       in   1    lookup requires invalidation (qualified with strobe)
//  ifill         in   1    lookup is an ifill (qualified with strobe)
//  cpu           in   1    issuing CPU (qualified with strobe)
//  address       in   40   lookup address (qualified with strobe)
//  inval_vect0   in   112  directory invalidation vector, way set 0
//  inval_vect1   in   112  directory invalidation vector, way set 1
//  pkt_valid     out  1    packet available
//  pkt_ready     in   1    consumer accepts packet when pkt_valid&&pkt_ready
//  pkt_vect      out  112  invalidation vector of current packet
//  pkt_addr      out  40   captured address of current entry
//  pkt_cpu       out  1    captured issuing CPU
//  pkt_second    out  1    1 = packet carries inval_vect1 (second of an ifill pair)
//  q_full        out  1    FIFO count == DEPTH
//  q_count       out  5    FIFO occupancy, 0..DEPTH
//  overflow      out  1    sticky: capture dropped because FIFO was full
// BEHAVIOUR
//  Reset (reset==0, async): FIFO empty, all delay-line bits 0, state IDLE,
//   pkt_valid=0, pkt_second=0, pkt_vect=0, pkt_addr=0, pkt_cpu=0,
//   q_full=0, q_count=0, overflow=0.
//  Capture: strobe&&needinv latches {ifill,cpu,address} into a DIR_LAT-deep
//   shift line; capture slot fires exactly DIR_LAT cycles after strobe and samples
//   inval_vect0/1 that cycle. Back-to-back strobes are supported (one per cycle).
//  HIT(v) = OR of v bits {0,1,4,5,32,35,56,57,60,61,88,91}.
//  Push when capture slot valid and (HIT(vect0) || (ifill && HIT(vect1))).
//   Entry stores vect0, vect1, address, cpu, dual = ifill && HIT(vect1),
//   first = HIT(vect0). No hit in either -> no push, no packet.
//  Push while full: accepted only if a pop completes the same cycle (count holds);
//   otherwise entry dropped, overflow<=1 (cleared only by reset).
//  Drain FSM on head entry (registered outputs):
//   IDLE : FIFO nonempty -> SEND0 if first else SEND1; pkt_valid<=1.
//   SEND0: pkt_vect=vect0, pkt_second=0. On accept: dual -> SEND1;
//          else pop, then next entry (SEND0/SEND1) or IDLE.
//   SEND1: pkt_vect=vect1, pkt_second=1. On accept: pop, next entry or IDLE.
//  Outputs stable while pkt_valid && !pkt_ready; pkt_valid never drops without
//   accept. Full throughput: one packet per cycle with pkt_ready held 1.
//  Latency: push at capture cycle C -> pkt_valid earliest at C+1 (empty FIFO).
//  q_count = entries incl. head in flight; pointers wrap modulo DEPTH.
// TESTING
//  1 DIR_LAT=1: strobe,needinv,addr=0x12_3456_7890, vect0 bit0=1 next cycle
//    -> pkt_valid 2 cycles after strobe, pkt_vect bit0=1, pkt_second=0, addr match.
//  2 ifill strobe, vect0 bit1=1, vect1 bit32=1, pkt_ready=1 -> two consecutive
//    packets, pkt_second 0 then 1, q_count returns to 0.
//  3 vect0 and vect1 all-zero hit bits -> no pkt_valid, q_count stays 0.
//  4 pkt_ready=0, 5 hit lookups, DEPTH=4 -> q_full=1 after 4th, overflow=1 after 5th;
//    then pkt_ready=1 -> exactly 4 packets in order.
//  5 full FIFO, capture and accept same cycle -> no overflow, count stays 4.
//  6 reset asserted mid-SEND1 -> pkt_valid, q_count, overflow 0 immediately;
//    strobe issued during reset produces no packet.

Source files
------------

// File: rtl/l1inv_pktq.sv
// Invalidation packet queue behind the L1 directory: aligns lookup context with
// the delayed directory vectors, filters misses, queues hits, and drains them as packets.
module l1inv_pktq #(
    parameter int DIR_LAT = 1,
    parameter int DEPTH   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         strobe,
    input  logic         needinv,
    input  logic         ifill,
    input  logic         cpu,
    input  logic [39:0]  address,
    input  logic [111:0] inval_vect0,
    input  logic [111:0] inval_vect1,
    output logic         pkt_valid,
    input  logic         pkt_ready,
    output logic [111:0] pkt_vect,
    output logic [39:0]  pkt_addr,
    output logic         pkt_cpu,
    output logic         pkt_second,
    output logic         q_full,
    output logic [4:0]   q_count,
    output logic         overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_t;

    function automatic logic hit(input logic [111:0] v);
        return v[0] | v[1] | v[4] | v[5] | v[32] | v[35] |
               v[56] | v[57] | v[60] | v[61] | v[88] | v[91];
    endfunction

    logic [DIR_LAT-1:0] line_vld_p;
    logic [DIR_LAT-1:0] line_ifill_p;
    logic [DIR_LAT-1:0] line_cpu_p;
    logic [39:0]        line_addr_p [DIR_LAT];

    logic [111:0] mem_vect0 [DEPTH];
    logic [111:0] mem_vect1 [DEPTH];
    logic [39:0]  mem_addr  [DEPTH];
    logic [DEPTH-1:0] mem_cpu;
    logic [DEPTH-1:0] mem_dual;
    logic [DEPTH-1:0] mem_first;

    logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [4:0]    count, rem;
    state_t        state, state_n;

    logic         cap_vld, cap_ifill, cap_cpu;
    logic [39:0]  cap_addr;
    logic         hit0, hit1, push_req, push, pop, accept, cur_dual;
    logic         head_from_mem, has_next;
    logic [111:0] nxt_vect0, nxt_vect1;
    logic [39:0]  nxt_addr;
    logic         nxt_cpu, nxt_first;
    logic         valid_n, second_n, cpu_n;
    logic [111:0] vect_n;
    logic [39:0]  addr_n;

    // Stage: lookup context travels alongside the directory access latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_vld_p   <= '0;
            line_ifill_p <= '0;
            line_cpu_p   <= '0;
            for (int i = 0; i < DIR_LAT; i++) line_addr_p[i] <= '0;
        end else begin
            line_vld_p[0]   <= strobe && needinv;
            line_ifill_p[0] <= ifill;
            line_cpu_p[0]   <= cpu;
            line_addr_p[0]  <= address;
            for (int i = 1; i < DIR_LAT; i++) begin
                line_vld_p[i]   <= line_vld_p[i-1];
                line_ifill_p[i] <= line_ifill_p[i-1];
                line_cpu_p[i]   <= line_cpu_p[i-1];
                line_addr_p[i]  <= line_addr_p[i-1];
            end
        end
    end

    assign cap_vld   = line_vld_p[DIR_LAT-1];
    assign cap_ifill = line_ifill_p[DIR_LAT-1];
    assign cap_cpu   = line_cpu_p[DIR_LAT-1];
    assign cap_addr  = line_addr_p[DIR_LAT-1];

    assign hit0     = hit(inval_vect0);
    assign hit1     = hit(inval_vect1);
    assign push_req = cap_vld && (hit0 || (cap_ifill && hit1));

    assign accept   = pkt_valid && pkt_ready;
    assign cur_dual = mem_dual[rd_ptr];
    assign pop      = accept && ((state == SEND1) || (state == SEND0 && !cur_dual));
    assign push     = push_req && (!q_full || pop);
    assign rd_ptr_n = pop ? rd_ptr + PW'(1) : rd_ptr;
    assign rem      = count - {4'b0, pop};

    // An empty queue forwards the capture directly so a packet appears the cycle after capture
    assign head_from_mem = (rem != 5'd0);
    assign has_next      = head_from_mem || push;
    assign nxt_vect0     = head_from_mem ? mem_vect0[rd_ptr_n] : inval_vect0;
    assign nxt_vect1     = head_from_mem ? mem_vect1[rd_ptr_n] : inval_vect1;
    assign nxt_addr      = head_from_mem ? mem_addr[rd_ptr_n]  : cap_addr;
    assign nxt_cpu       = head_from_mem ? mem_cpu[rd_ptr_n]   : cap_cpu;
    assign nxt_first     = head_from_mem ? mem_first[rd_ptr_n] : hit0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_vect0[wr_ptr] <= inval_vect0;
            mem_vect1[wr_ptr] <= inval_vect1;
            mem_addr[wr_ptr]  <= cap_addr;
            mem_cpu[wr_ptr]   <= cap_cpu;
            mem_dual[wr_ptr]  <= cap_ifill && hit1;
            mem_first[wr_ptr] <= hit0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr   <= rd_ptr_n;
            count    <= count + {4'b0, push} - {4'b0, pop};
            overflow <= overflow | (push_req && !push);
        end
    end

    assign q_count = count;
    assign q_full  = (count == 5'(DEPTH));

    // Stage: drain FSM state and registered packet outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pkt_valid  <= 1'b0;
            pkt_second <= 1'b0;
            pkt_vect   <= '0;
            pkt_addr   <= '0;
            pkt_cpu    <= 1'b0;
        end else begin
            state      <= state_n;
            pkt_valid  <= valid_n;
            pkt_second <= second_n;
            if (valid_n) begin
                pkt_vect <= vect_n;
                pkt_addr <= addr_n;
                pkt_cpu  <= cpu_n;
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (has_next) state_n = nxt_first ? SEND0 : SEND1;
            end
            SEND0: begin
                if (accept) begin
                    if (cur_dual)      state_n = SEND1;
                    else if (has_next) state_n = nxt_first ? SEND0 : SEND1;
                    else               state_n = IDLE;
                end
            end
            SEND1: begin
                if (accept) begin
                    if (has_next) state_n = nxt_first ? SEND0 : SEND1;
                    else          state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        valid_n  = (state_n != IDLE);
        second_n = (state_n == SEND1);
        vect_n   = (state_n == SEND1) ? nxt_vect1 : nxt_vect0;
        addr_n   = nxt_addr;
        cpu_n    = nxt_cpu;
    end

endmodule

// File: tb/tb_l1inv_pktq.sv
// Scoreboard bench for l1inv_pktq: lookups push expected packets, a negedge
// monitor pops and compares them on every accepted transfer.
module tb_l1inv_pktq;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         strobe = 1'b0, needinv = 1'b0, ifill = 1'b0, cpu = 1'b0;
    logic [39:0]  address = '0;
    logic [111:0] inval_vect0 = '0, inval_vect1 = '0;
    logic         pkt_ready = 1'b0;
    logic         pkt_valid, pkt_cpu, pkt_second, q_full, overflow;
    logic [111:0] pkt_vect;
    logic [39:0]  pkt_addr;
    logic [4:0]   q_count;

    l1inv_pktq #(.DIR_LAT(1), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .strobe(strobe), .needinv(needinv),
        .ifill(ifill), .cpu(cpu), .address(address),
        .inval_vect0(inval_vect0), .inval_vect1(inval_vect1),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_vect(pkt_vect),
        .pkt_addr(pkt_addr), .pkt_cpu(pkt_cpu), .pkt_second(pkt_second),
        .q_full(q_full), .q_count(q_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [111:0] vect;
        logic [39:0]  addr;
        logic         cpu;
        logic         second;
    } pkt_t;

    pkt_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   hit_idx[12] = '{0, 1, 4, 5, 32, 35, 56, 57, 60, 61, 88, 91};

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    endtask

    function automatic logic [111:0] bitv(input int i);
        logic [111:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic bit ref_hit(input logic [111:0] v);
        bit h;
        h = 1'b0;
        foreach (hit_idx[i]) h |= v[hit_idx[i]];
        return h;
    endfunction

    // strobe in one cycle, directory vectors and capture-cycle ready the next
    task automatic lookup(input bit ifl, input bit c, input logic [39:0] a,
                          input logic [111:0] v0, input logic [111:0] v1,
                          input bit drop, input bit rdy_cap);
        @(posedge clk); #1;
        strobe = 1'b1; needinv = 1'b1; ifill = ifl; cpu = c; address = a;
        inval_vect0 = '0; inval_vect1 = '0;
        @(posedge clk); #1;
        strobe = 1'b0; needinv = 1'b0;
        inval_vect0 = v0; inval_vect1 = v1; pkt_ready = rdy_cap;
        if (!drop) begin
            if (ref_hit(v0))        exp_q.push_back('{v0, a, c, 1'b0});
            if (ifl && ref_hit(v1)) exp_q.push_back('{v1, a, c, 1'b1});
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; strobe = 1'b0; pkt_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic drain_check(input string tag);
        #1 pkt_ready = 1'b1;
        repeat (10) @(negedge clk);
        check({tag, "_qcount"}, q_count, 0);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    pkt_t e, held;
    bit   hold = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("stable_valid", pkt_valid, 1);
                check("stable_vect", pkt_vect, held.vect);
            end
            if (pkt_valid && pkt_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pkt", pkt_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pkt_vect", pkt_vect, e.vect);
                    check("pkt_addr", pkt_addr, e.addr);
                    check("pkt_cpu", pkt_cpu, e.cpu);
                    check("pkt_second", pkt_second, e.second);
                end
            end
            hold = pkt_valid && !pkt_ready;
            held = '{pkt_vect, pkt_addr, pkt_cpu, pkt_second};
        end
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_valid", pkt_valid, 0);
        check("rst_second", pkt_second, 0);
        check("rst_vect", pkt_vect, 0);
        check("rst_addr", pkt_addr, 0);
        check("rst_cpu", pkt_cpu, 0);
        check("rst_full", q_full, 0);
        check("rst_count", q_count, 0);
        check("rst_ovf", overflow, 0);
        @(posedge clk); #1 reset = 1'b1;

        // single hit, latency and head contents
        lookup(1'b0, 1'b1, 40'h12_3456_7890, bitv(0), '0, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_early", pkt_valid, 0);
        @(negedge clk);
        check("t1_valid", pkt_valid, 1);
        check("t1_vect", pkt_vect, bitv(0));
        check("t1_second", pkt_second, 0);
        check("t1_addr", pkt_addr, 40'h12_3456_7890);
        check("t1_count", q_count, 1);
        @(posedge clk);
        drain_check("t1");

        // ifill pair, back-to-back packets
        lookup(1'b1, 1'b0, 40'hAB_CDEF_0123, bitv(1), bitv(32), 1'b0, 1'b1);
        @(negedge clk);
        check("t2_early", pkt_valid, 0);
        @(negedge clk);
        check("t2_v0", pkt_valid, 1);
        check("t2_s0", pkt_second, 0);
        @(negedge clk);
        check("t2_v1", pkt_valid, 1);
        check("t2_s1", pkt_second, 1);
        repeat (2) @(negedge clk);
        check("t2_count", q_count, 0);

        // no hit bits anywhere
        lookup(1'b1, 1'b0, 40'h00_0000_0040, bitv(2) | bitv(100), bitv(3) | bitv(33), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_novalid", pkt_valid, 0);
        end
        check("t3_count", q_count, 0);

        // ifill hitting only way set 1 gives one second-half packet
        lookup(1'b1, 1'b1, 40'h55_0000_1000, bitv(3), bitv(91), 1'b0, 1'b1);
        @(posedge clk);
        drain_check("t3b");

        // fill, overflow, ordered drain
        for (int k = 0; k < 5; k++) begin
            lookup(1'b0, k[0], 40'h10_0000_0000 + 40'(k), bitv(hit_idx[k]), '0, k == 4, 1'b0);
            @(negedge clk);
            @(negedge clk);
            if (k == 3) begin
                check("t4_full", q_full, 1);
                check("t4_count4", q_count, 4);
                check("t4_noovf", overflow, 0);
            end
        end
        check("t4_ovf", overflow, 1);
        check("t4_count_hold", q_count, 4);
        @(posedge clk);
        drain_check("t4");

        // reset while the second half of an ifill pair is pending
        #1 pkt_ready = 1'b0;
        lookup(1'b1, 1'b1, 40'h77_0000_2222, bitv(5), bitv(35), 1'b0, 1'b0);
        @(posedge clk); #1 pkt_ready = 1'b1;
        @(posedge clk); #1 pkt_ready = 1'b0;
        @(negedge clk);
        check("t6_second", pkt_second, 1);
        check("t6_valid", pkt_valid, 1);
        #2 reset = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_valid", pkt_valid, 0);
        check("t6_rst_count", q_count, 0);
        check("t6_rst_ovf", overflow, 0);
        @(posedge clk); #1 strobe = 1'b1; needinv = 1'b1; ifill = 1'b0;
        @(posedge clk); #1 strobe = 1'b0; needinv = 1'b0; inval_vect0 = bitv(0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_nopkt", pkt_valid, 0);
        check("t6_count", q_count, 0);

        // push into a full queue while the head is accepted
        do_reset();
        for (int k = 0; k < 4; k++)
            lookup(1'b0, 1'b0, 40'h20_0000_0000 + 40'(k), bitv(hit_idx[k + 4]), '0, 1'b0, 1'b0);
        lookup(1'b0, 1'b1, 40'h20_0000_00FF, bitv(88), '0, 1'b0, 1'b1);
        @(posedge clk); #1 pkt_ready = 1'b0;
        @(negedge clk);
        check("t5_count", q_count, 4);
        check("t5_full", q_full, 1);
        check("t5_noovf", overflow, 0);
        @(posedge clk);
        drain_check("t5");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
